exe_muldiv_unit: RTL and testbench
==================================

Name: exe_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit for the EXE stage of the 5-stage pipeline. Successor to the fixed 32-bit multi-cycle multiplier.
- Supports signed and unsigned multiply and divide, selectable multiply radix, and a cancel input for pipeline flush.
- Produces HI/LO results with a busy/done handshake. EXE_over is derived from it as "valid & (~muldiv_op | done)".

Parameters:
WIDTH, 32, operand width in bits; product and {remainder, quotient} are 2*WIDTH
MUL_STEP, 1, multiplier bits consumed per cycle; legal values 1, 2, 4; must divide WIDTH

Ports:
clk  input  1  clock, all state updates on rising edge
resetn  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
src1  input  WIDTH  multiplicand / dividend
src2  input  WIDTH  multiplier / divisor
cancel  input  1  synchronous abort (EXE flush)
busy  output  1  high from the accept edge until done or cancel
done  output  1  one-cycle completion pulse
hi  output  WIDTH  product[2W-1:W] or remainder
lo  output  WIDTH  product[W-1:0] or quotient
div_by_zero  output  1  valid while done=1; set for DIV/DIVU with src2=0

Behaviour:
- Reset (resetn=0, asynchronous): state IDLE; busy, done, div_by_zero, hi and lo all 0. Reset mid-operation discards the operation; no done pulse.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - start=1 and cancel=0 → latch op, operand signs, and absolute values (signed ops) or raw values (unsigned ops).
  - Next state MUL or DIV; busy=1 from that edge.
  - DIV with src2=0 → go directly to FIX.
- MUL: shift-add on magnitudes, MUL_STEP bits per edge, K = WIDTH/MUL_STEP edges, then FIX.
- DIV: restoring division, 1 quotient bit per edge, WIDTH edges, then FIX.
- FIX: one edge that applies signs and writes hi/lo, then DONE.
  - Signed multiply: negate the full 2W product if sign1 ^ sign2.
  - Signed divide: quotient negated if sign1 ^ sign2; remainder takes the dividend's sign.
  - -2^(W-1) / -1: lo = 0x80000000, hi = 0 (wrap, no trap).
  - Divide by zero: hi = src1, lo = all ones, div_by_zero=1.
- DONE: done=1 for exactly this one cycle; busy=0 in this cycle; next edge returns to IDLE and clears done and div_by_zero.
  - A start seen in DONE is ignored; a new op is accepted only from IDLE.
- Latency from the accept edge to the edge that raises done:
  - multiply: K+2 edges
  - divide: WIDTH+2 edges
  - divide by zero: 2 edges
- hi/lo change only at the FIX edge and hold until the next FIX.
- start while busy is ignored; operands are latched, so src1, src2 and op may change after acceptance.
- cancel=1 in MUL, DIV or FIX → IDLE on the next edge; busy=0, no done, hi/lo unchanged.
- cancel has priority over start in IDLE: the op is not accepted.
- cancel in DONE has no effect; the pulse already occurred.

Test Plan:
- WIDTH=32, MUL_STEP=1, MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, done exactly 34 edges after the accept edge, busy high for 33 cycles.
- MULT -3 × 5 with MUL_STEP=4 → hi=0xFFFFFFFF, lo=0xFFFFFFF1, done at edge 10; repeat with MUL_STEP=2 → done at edge 18.
- DIV -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0; DIVU 100/7 → lo=14, hi=2; each done at edge 34.
- DIVU 0x1234 / 0 → done at edge 2 with div_by_zero=1, hi=0x1234, lo=0xFFFFFFFF; the next normal op reports div_by_zero=0.
- MULT started, cancel at edge 10 → busy=0 at edge 11, no done ever, hi/lo keep previous values; start+cancel together in IDLE → not accepted.
- start pulsed while busy with different operands → ignored, result matches the original op; resetn low at edge 15 of a divide → all outputs 0 immediately, no done after release.

Source files
------------

// File: rtl/exe_muldiv_unit.sv
// Iterative multiply/divide unit for the EXE stage.
// Multiply: shift-add on operand magnitudes, MUL_STEP multiplier bits per cycle.
// Divide: restoring division, one quotient bit per cycle.
// Signs are applied in a single FIX cycle. done pulses for one cycle in DONE.
module exe_muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int K  = WIDTH / MUL_STEP;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Conditional two's-complement negation, operand width.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
        logic [WIDTH-1:0] r;
        if (en) r = ~v + WIDTH'(1);
        else    r = v;
        return r;
    endfunction

    // Conditional two's-complement negation, double width.
    function automatic logic [W2-1:0] neg_d(input logic [W2-1:0] v, input logic en);
        logic [W2-1:0] r;
        if (en) r = ~v + W2'(1);
        else    r = v;
        return r;
    endfunction

    state_t                   state_r, state_n_s;
    logic                     accept_s;
    logic                     is_div_r, sign1_r, sign2_r, dbz_r;
    logic [WIDTH-1:0]         opnd_r;      // multiplicand or divisor magnitude
    logic [W2-1:0]            acc_r;       // {product hi, multiplier/product lo} or {remainder, quotient}
    logic [CW-1:0]            cnt_r;
    logic                     busy_r, done_r, dbz_out_r;
    logic [WIDTH-1:0]         hi_r, lo_r;

    logic                     op_signed_s, s1_s, s2_s, src2_zero_s;
    logic [WIDTH-1:0]         mag1_s, mag2_s;
    logic [WIDTH+MUL_STEP-1:0] partial_s, upper_sum_s;
    logic [W2-1:0]            mul_next_s, div_next_s, prod_s;
    logic [WIDTH:0]           trial_s, diff_s;
    logic [WIDTH-1:0]         fix_hi_s, fix_lo_s;

    // Operand decode: signs only matter for the signed ops.
    always_comb begin
        op_signed_s = ~op[0];
        s1_s        = op_signed_s & src1[WIDTH-1];
        s2_s        = op_signed_s & src2[WIDTH-1];
        mag1_s      = neg_w(src1, s1_s);
        mag2_s      = neg_w(src2, s2_s);
        src2_zero_s = (src2 == {WIDTH{1'b0}});
    end

    // One multiply step: add opnd * (low MUL_STEP multiplier bits) into the upper half, then shift right.
    always_comb begin
        partial_s   = {{MUL_STEP{1'b0}}, opnd_r} * {{WIDTH{1'b0}}, acc_r[MUL_STEP-1:0]};
        upper_sum_s = {{MUL_STEP{1'b0}}, acc_r[W2-1:WIDTH]} + partial_s;
        mul_next_s  = {upper_sum_s, acc_r[WIDTH-1:MUL_STEP]};
    end

    // One restoring-divide step; the remainder stays below the divisor, so bit WIDTH of diff is the borrow.
    always_comb begin
        trial_s = acc_r[W2-1:WIDTH-1];
        diff_s  = trial_s - {1'b0, opnd_r};
        if (!diff_s[WIDTH]) begin
            div_next_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end else begin
            div_next_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
        end
    end

    // Sign fix-up of the magnitude result; divide-by-zero rebuilds the raw dividend.
    always_comb begin
        prod_s = neg_d(acc_r, sign1_r ^ sign2_r);
        if (dbz_r) begin
            fix_hi_s = neg_w(acc_r[WIDTH-1:0], sign1_r);
            fix_lo_s = {WIDTH{1'b1}};
        end else if (is_div_r) begin
            fix_hi_s = neg_w(acc_r[W2-1:WIDTH], sign1_r);
            fix_lo_s = neg_w(acc_r[WIDTH-1:0], sign1_r ^ sign2_r);
        end else begin
            fix_hi_s = prod_s[W2-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Next-state logic; cancel beats start in IDLE and aborts MUL/DIV/FIX.
    always_comb begin
        state_n_s = state_r;
        accept_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !cancel) begin
                    accept_s = 1'b1;
                    if (!op[1])          state_n_s = ST_MUL;
                    else if (src2_zero_s) state_n_s = ST_FIX;
                    else                 state_n_s = ST_DIV;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (cancel)                      state_n_s = ST_IDLE;
                else if (cnt_r == {CW{1'b0}})    state_n_s = ST_FIX;
                else                             state_n_s = state_r;
            end
            ST_FIX: begin
                if (cancel) state_n_s = ST_IDLE;
                else        state_n_s = ST_DONE;
            end
            ST_DONE: state_n_s = ST_IDLE;
            default: state_n_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_r <= ST_IDLE;
        else         state_r <= state_n_s;
    end

    // Operand latch on accept and iteration of the shared accumulator.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            is_div_r <= 1'b0;
            sign1_r  <= 1'b0;
            sign2_r  <= 1'b0;
            dbz_r    <= 1'b0;
            opnd_r   <= {WIDTH{1'b0}};
            acc_r    <= {W2{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (accept_s) begin
            is_div_r <= op[1];
            sign1_r  <= s1_s;
            sign2_r  <= s2_s;
            dbz_r    <= op[1] & src2_zero_s;
            if (op[1]) begin
                opnd_r <= mag2_s;
                acc_r  <= {{WIDTH{1'b0}}, mag1_s};
                cnt_r  <= CW'(WIDTH - 1);
            end else begin
                opnd_r <= mag1_s;
                acc_r  <= {{WIDTH{1'b0}}, mag2_s};
                cnt_r  <= CW'(K - 1);
            end
        end else if (state_r == ST_MUL) begin
            acc_r <= mul_next_s;
            cnt_r <= cnt_r - CW'(1);
        end else if (state_r == ST_DIV) begin
            acc_r <= div_next_s;
            cnt_r <= cnt_r - CW'(1);
        end else begin
            acc_r <= acc_r;
        end
    end

    // Registered handshake outputs and result write at the FIX edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dbz_out_r <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
        end else begin
            busy_r    <= (state_n_s == ST_MUL) || (state_n_s == ST_DIV) || (state_n_s == ST_FIX);
            done_r    <= (state_n_s == ST_DONE);
            dbz_out_r <= (state_n_s == ST_DONE) && dbz_r;
            if ((state_r == ST_FIX) && !cancel) begin
                hi_r <= fix_hi_s;
                lo_r <= fix_lo_s;
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_out_r;
    assign hi          = hi_r;
    assign lo          = lo_r;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Scoreboard bench for exe_muldiv_unit: three instances (MUL_STEP 1, 2, 4)
// share one stimulus; each operation names the instance whose result is checked.
module tb_exe_muldiv_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        cancel;
    logic [1:0]  op;
    logic [31:0] src1, src2;

    logic [2:0]        busy_v, done_v, dbz_v;
    logic [2:0][31:0]  hi_v, lo_v;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    exe_muldiv_unit #(.WIDTH(32), .MUL_STEP(1)) u_dut_s1 (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .src1(src1), .src2(src2),
        .cancel(cancel), .busy(busy_v[0]), .done(done_v[0]), .hi(hi_v[0]), .lo(lo_v[0]),
        .div_by_zero(dbz_v[0]));

    exe_muldiv_unit #(.WIDTH(32), .MUL_STEP(2)) u_dut_s2 (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .src1(src1), .src2(src2),
        .cancel(cancel), .busy(busy_v[1]), .done(done_v[1]), .hi(hi_v[1]), .lo(lo_v[1]),
        .div_by_zero(dbz_v[1]));

    exe_muldiv_unit #(.WIDTH(32), .MUL_STEP(4)) u_dut_s4 (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .src1(src1), .src2(src2),
        .cancel(cancel), .busy(busy_v[2]), .done(done_v[2]), .hi(hi_v[2]), .lo(lo_v[2]),
        .div_by_zero(dbz_v[2]));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: {hi, lo} for a non-zero divisor, or any multiply.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        longint      sa, sbv, q, rm;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (o)
            2'b00: r = 64'(sa * sbv);
            2'b01: r = {32'd0, a} * {32'd0, b};
            2'b10: begin
                q  = sa / sbv;
                rm = sa % sbv;
                r  = {rm[31:0], q[31:0]};
            end
            2'b11: r = {a % b, a / b};
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (((busy_v != 3'b000) || (done_v != 3'b000)) && (n < 200)) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_reached", 64'(n < 200), 64'd1);
        @(negedge clk);
    endtask

    task automatic run_op(input int idx, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edbz, input int elat, input bit poke, input string tag);
        exp_t e;
        int   edges;
        int   busy_cnt;
        bit   got;
        e.hi  = ehi;
        e.lo  = elo;
        e.dbz = edbz;
        e.lat = elat;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b1; op = o; src1 = a; src2 = b; cancel = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = ~o; src1 = ~a; src2 = ~b ^ 32'h5;
        edges = 1; busy_cnt = 0; got = 1'b0;
        while (edges < 200) begin
            if (done_v[idx]) begin
                got = 1'b1;
                break;
            end
            if (busy_v[idx]) busy_cnt++;
            if (poke && (edges == 5)) start = 1'b1;
            else                      start = 1'b0;
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        e = sb_q.pop_front();
        if (!got) begin
            check_eq({tag, "_timeout"}, 64'(got), 64'd1);
        end else begin
            check_eq({tag, "_hi"}, 64'(hi_v[idx]), 64'(e.hi));
            check_eq({tag, "_lo"}, 64'(lo_v[idx]), 64'(e.lo));
            check_eq({tag, "_dbz"}, 64'(dbz_v[idx]), 64'(e.dbz));
            check_eq({tag, "_lat"}, 64'(edges), 64'(e.lat));
            check_eq({tag, "_busy_at_done"}, 64'(busy_v[idx]), 64'd0);
            check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(e.lat - 1));
        end
        wait_idle();
    endtask

    initial begin
        logic [63:0] r;
        logic [31:0] a, b, prev_hi, prev_lo;
        logic [1:0]  o;
        int          edges, dcnt;

        resetn = 1'b0; start = 1'b0; cancel = 1'b0; op = 2'b00; src1 = 32'd0; src2 = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_ctrl", 64'({busy_v, done_v, dbz_v}), 64'd0);
        check_eq("rst_hi", 64'(hi_v[0]), 64'd0);
        check_eq("rst_lo", 64'(lo_v[0]), 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        run_op(0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, 1'b0, "multu_max");
        run_op(2, 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 10, 1'b0, "mult_s4");
        run_op(1, 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 18, 1'b0, "mult_s2");
        run_op(0, 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 34, 1'b0, "mult_s1");
        run_op(0, 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 1'b0, "div_neg");
        run_op(0, 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 34, 1'b0, "div_ovf");
        run_op(0, 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 1'b0, "divu");
        run_op(0, 2'b11, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b1, 2, 1'b0, "divu_zero");
        run_op(0, 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 1'b0, "divu_after_zero");
        run_op(0, 2'b10, 32'hFFFFFF00, 32'd0, 32'hFFFFFF00, 32'hFFFFFFFF, 1'b1, 2, 1'b0, "div_zero_neg");
        run_op(0, 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 1'b1, "divu_poke");

        for (int i = 0; i < 8; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom >> $urandom_range(0, 28);
            if (b == 32'd0) b = 32'd1;
            if ((o == 2'b10) && (a == 32'h80000000) && (b == 32'hFFFFFFFF)) b = 32'd3;
            r = model(o, a, b);
            run_op(0, o, a, b, r[63:32], r[31:0], 1'b0, 34, 1'b0, "rand");
        end

        // Cancel a multiply mid-flight: no done, results held.
        prev_hi = hi_v[0];
        prev_lo = lo_v[0];
        @(negedge clk);
        start = 1'b1; op = 2'b00; src1 = 32'd7; src2 = 32'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        while (edges < 10) begin
            @(negedge clk);
            edges++;
        end
        check_eq("cancel_busy_pre", 64'(busy_v[0]), 64'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check_eq("cancel_busy", 64'(busy_v[0]), 64'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_v[0]) dcnt++;
        end
        check_eq("cancel_no_done", 64'(dcnt), 64'd0);
        check_eq("cancel_hi_held", 64'(hi_v[0]), 64'(prev_hi));
        check_eq("cancel_lo_held", 64'(lo_v[0]), 64'(prev_lo));
        wait_idle();

        // start together with cancel in IDLE is not accepted.
        start = 1'b1; cancel = 1'b1; op = 2'b01; src1 = 32'd3; src2 = 32'd3;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check_eq("startcancel_busy", 64'(busy_v), 64'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_v != 3'b000) dcnt++;
        end
        check_eq("startcancel_no_done", 64'(dcnt), 64'd0);

        // Asynchronous reset in the middle of a divide.
        run_op(0, 2'b11, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 34, 1'b0, "divu_pre_rst");
        start = 1'b1; op = 2'b10; src1 = 32'd1000; src2 = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        while (edges < 15) begin
            @(negedge clk);
            edges++;
        end
        check_eq("rst_mid_busy_pre", 64'(busy_v[0]), 64'd1);
        resetn = 1'b0;
        #1;
        check_eq("rst_mid_ctrl", 64'({busy_v, done_v, dbz_v}), 64'd0);
        check_eq("rst_mid_hi", 64'(hi_v[0]), 64'd0);
        check_eq("rst_mid_lo", 64'(lo_v[0]), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done_v != 3'b000) dcnt++;
        end
        check_eq("rst_mid_no_done", 64'(dcnt), 64'd0);
        check_eq("rst_mid_hi_after", 64'(hi_v[0]), 64'd0);

        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
